// File: rtl/fwgpio_irq_pkg.sv
// Shared definitions for the fwgpio edge-detect interrupt block:
// register word offsets and bus handshake state encoding.
package fwgpio_irq_pkg;

    localparam logic [3:0] REG_SYNC    = 4'd0;
    localparam logic [3:0] REG_RISE_EN = 4'd1;
    localparam logic [3:0] REG_FALL_EN = 4'd2;
    localparam logic [3:0] REG_PEND    = 4'd3;
    localparam logic [3:0] REG_MASK    = 4'd4;
    localparam logic [3:0] REG_RAW     = 4'd5;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/fwgpio_edge_det.sv
// Per-pin synchroniser, previous-value flop and qualified rise/fall detect.
// Edges stay suppressed until the pipeline has refilled after reset.
module fwgpio_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   arm_q;

    // Synchroniser chain, previous-value flop and post-reset arming shifter
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // arm_q top bit rises once both the sync value and prev_q hold real pad samples
    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = arm_q[SYNC_STAGES] &  sync_o & ~prev_q;
    assign fall_o = arm_q[SYNC_STAGES] & ~sync_o &  prev_q;

endmodule

// File: rtl/fwgpio_irq.sv
// Edge-detect interrupt stage beside fwgpio: sticky pending bits per pin,
// per-pin masking and a registered level interrupt, on its own rt_ bus window.
module fwgpio_irq
    import fwgpio_irq_pkg::*;
#(
    parameter int N_PINS      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        rt_adr,
    input  logic [31:0]       rt_dat_w,
    output logic [31:0]       rt_dat_r,
    input  logic              rt_valid,
    input  logic              rt_we,
    output logic              rt_ready,
    input  logic [N_PINS-1:0] pin_i,
    output logic              irq
);

    logic [N_PINS-1:0] sync_s;
    logic [N_PINS-1:0] rise_s;
    logic [N_PINS-1:0] fall_s;
    logic [N_PINS-1:0] set_s;
    logic [N_PINS-1:0] clr_s;
    logic [N_PINS-1:0] wdat_s;
    logic [31:0]       rd_s;
    logic              wr_s;

    logic [N_PINS-1:0] rise_en_q, rise_en_d;
    logic [N_PINS-1:0] fall_en_q, fall_en_d;
    logic [N_PINS-1:0] pend_q, pend_d;
    logic [N_PINS-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;
    logic              ready_q, ready_d;
    logic [31:0]       dat_r_q, dat_r_d;
    bus_state_e        state_q, state_d;

    function automatic logic [31:0] zext(input logic [N_PINS-1:0] v);
        logic [31:0] r;
        r            = 32'd0;
        r[N_PINS-1:0] = v;
        return r;
    endfunction

    for (genvar n = 0; n < N_PINS; n++) begin : g_pin
        fwgpio_edge_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_edge (
            .clock (clock),
            .reset (reset),
            .pin_i (pin_i[n]),
            .sync_o(sync_s[n]),
            .rise_o(rise_s[n]),
            .fall_o(fall_s[n])
        );
    end

    // Register read mux; holes in the map read as zero
    always_comb begin
        case (rt_adr)
            REG_SYNC:    rd_s = zext(sync_s);
            REG_RISE_EN: rd_s = zext(rise_en_q);
            REG_FALL_EN: rd_s = zext(fall_en_q);
            REG_PEND:    rd_s = zext(pend_q);
            REG_MASK:    rd_s = zext(mask_q);
            REG_RAW:     rd_s = zext(pend_q & mask_q);
            default:     rd_s = 32'd0;
        endcase
    end

    // Bus handshake: accept in IDLE, acknowledge for one cycle in ACK
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        dat_r_d = dat_r_q;
        wr_s    = 1'b0;
        case (state_q)
            BUS_IDLE: begin
                if (rt_valid) begin
                    state_d = BUS_ACK;
                    ready_d = 1'b1;
                    wr_s    = rt_we;
                    dat_r_d = rt_we ? 32'd0 : rd_s;
                end else begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    assign wdat_s    = rt_dat_w[N_PINS-1:0];
    assign rise_en_d = (wr_s && (rt_adr == REG_RISE_EN)) ? wdat_s : rise_en_q;
    assign fall_en_d = (wr_s && (rt_adr == REG_FALL_EN)) ? wdat_s : fall_en_q;
    assign mask_d    = (wr_s && (rt_adr == REG_MASK))    ? wdat_s : mask_q;
    assign clr_s     = (wr_s && (rt_adr == REG_PEND))    ? wdat_s : '0;

    // A new edge in the same cycle as its W1C keeps the bit set
    assign set_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);
    assign pend_d = set_s | (pend_q & ~clr_s);
    assign irq_d  = |(pend_q & mask_q);

    // State, configuration and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= BUS_IDLE;
            ready_q   <= 1'b0;
            dat_r_q   <= 32'd0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            dat_r_q   <= dat_r_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    assign rt_ready = ready_q;
    assign rt_dat_r = dat_r_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_fwgpio_irq.sv
// Directed bench for fwgpio_irq with a pin-history reference model checked every cycle.
module tb_fwgpio_irq;

    localparam int SS = 2;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  rt_adr   = 4'd0;
    logic [31:0] rt_dat_w = 32'd0;
    logic [31:0] rt_dat_r;
    logic        rt_valid = 1'b0;
    logic        rt_we    = 1'b0;
    logic        rt_ready;
    logic [31:0] pin_i    = 32'd0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fwgpio_irq #(.N_PINS(32), .SYNC_STAGES(SS)) dut (
        .clock   (clock),
        .reset   (reset),
        .rt_adr  (rt_adr),
        .rt_dat_w(rt_dat_w),
        .rt_dat_r(rt_dat_r),
        .rt_valid(rt_valid),
        .rt_we   (rt_we),
        .rt_ready(rt_ready),
        .pin_i   (pin_i),
        .irq     (irq)
    );

    // Reference model: pad history per clock edge, edges derived from samples SS and SS+1 edges old
    logic [31:0] hist [0:4095];
    bit          hval [0:4095];
    int          cyc = 0;
    logic [31:0] m_re = 32'd0, m_fe = 32'd0, m_pend = 32'd0, m_mask = 32'd0, e_dat = 32'd0;
    logic        e_ready = 1'b0, e_irq = 1'b0;

    function automatic logic [31:0] m_sync(input int n);
        if (n >= SS && hval[n-SS]) return hist[n-SS];
        return 32'd0;
    endfunction

    always @(posedge clock) begin
        logic [31:0] s, p, set, clr, op, om;
        logic        nr;
        op = m_pend;
        om = m_mask;
        if (reset) begin
            hval[cyc] = 1'b0;
            m_re = 32'd0; m_fe = 32'd0; m_pend = 32'd0; m_mask = 32'd0;
            e_ready = 1'b0; e_dat = 32'd0; e_irq = 1'b0;
        end else begin
            hist[cyc] = pin_i;
            hval[cyc] = 1'b1;
            set = 32'd0;
            if (cyc >= SS + 1 && hval[cyc-SS] && hval[cyc-SS-1]) begin
                s   = hist[cyc-SS];
                p   = hist[cyc-SS-1];
                set = (s & ~p & m_re) | (~s & p & m_fe);
            end
            clr = 32'd0;
            nr  = rt_valid && !e_ready;
            if (nr) begin
                if (rt_we) begin
                    e_dat = 32'd0;
                    case (rt_adr)
                        4'd1:    m_re   = rt_dat_w;
                        4'd2:    m_fe   = rt_dat_w;
                        4'd3:    clr    = rt_dat_w;
                        4'd4:    m_mask = rt_dat_w;
                        default: ;
                    endcase
                end else begin
                    case (rt_adr)
                        4'd0:    e_dat = m_sync(cyc);
                        4'd1:    e_dat = m_re;
                        4'd2:    e_dat = m_fe;
                        4'd3:    e_dat = op;
                        4'd4:    e_dat = om;
                        4'd5:    e_dat = op & om;
                        default: e_dat = 32'd0;
                    endcase
                end
            end
            e_ready = nr;
            e_irq   = |(op & om);
            m_pend  = set | (op & ~clr);
        end
        cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (cyc > 0) begin
            checks++;
            if (irq !== e_irq) begin
                errors++;
                $display("FAIL model_irq cyc %0d actual %b required %b", cyc, irq, e_irq);
            end
            checks++;
            if (rt_ready !== e_ready) begin
                errors++;
                $display("FAIL model_ready cyc %0d actual %b required %b", cyc, rt_ready, e_ready);
            end
            if (e_ready) begin
                checks++;
                if (rt_dat_r !== e_dat) begin
                    errors++;
                    $display("FAIL model_rdata cyc %0d actual 0x%08h required 0x%08h", cyc, rt_dat_r, e_dat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; ready must be high one cycle after valid
    task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd);
        rt_valid = 1'b1; rt_we = we; rt_adr = a; rt_dat_w = d;
        @(negedge clock);
        chk("ready_latency", {31'd0, rt_ready}, 32'd1);
        rd = rt_dat_r;
        rt_valid = 1'b0; rt_we = 1'b0;
        @(negedge clock);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] x;
        bus(1'b1, a, d, x);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] x;
        bus(1'b0, a, 32'd0, x);
        chk(name, x, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        pin_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_ready", {31'd0, rt_ready}, 32'd0);
        chk("reset_rdata", rt_dat_r, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        rd_chk("sync_all_high", 4'd0, 32'hFFFF_FFFF);
        rd_chk("pend_after_reset", 4'd3, 32'd0);
        chk("irq_after_reset", {31'd0, irq}, 32'd0);

        // Rising edge on pin 0
        pin_i = 32'd0;
        repeat (6) @(negedge clock);
        wr(4'd1, 32'h1);
        wr(4'd4, 32'h1);
        pin_i[0] = 1'b1;
        for (int i = 0; i < SS + 2 && !irq; i++) @(negedge clock);
        chk("irq_pin0_rise", {31'd0, irq}, 32'd1);
        rd_chk("pend_pin0", 4'd3, 32'h1);
        wr(4'd3, 32'h1);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);
        rd_chk("pend_cleared", 4'd3, 32'd0);

        // Falling edge on pin 7, masked then unmasked
        pin_i[7] = 1'b1;
        repeat (6) @(negedge clock);
        wr(4'd2, 32'h80);
        pin_i[7] = 1'b0;
        repeat (6) @(negedge clock);
        rd_chk("pend_pin7_fall", 4'd3, 32'h80);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr(4'd4, 32'h80);
        chk("irq_unmasked", {31'd0, irq}, 32'd1);
        wr(4'd3, 32'h80);
        chk("irq_pin7_clear", {31'd0, irq}, 32'd0);

        // Pin 3 edge landing on the same cycle as its W1C
        wr(4'd1, 32'h8);
        pin_i[3] = 1'b1;
        repeat (6) @(negedge clock);
        rd_chk("pend_pin3_first", 4'd3, 32'h8);
        pin_i[3] = 1'b0;
        repeat (6) @(negedge clock);
        pin_i[3] = 1'b1;
        repeat (2) @(negedge clock);
        wr(4'd3, 32'h8);
        rd_chk("pend_set_wins", 4'd3, 32'h8);

        // Back-to-back reads and holes in the map
        rd_chk("rd_sync", 4'd0, 32'h0000_0009);
        rd_chk("rd_rise_en", 4'd1, 32'h8);
        rd_chk("rd_fall_en", 4'd2, 32'h80);
        rd_chk("rd_raw", 4'd5, 32'd0);
        wr(4'd9, 32'hDEAD_BEEF);
        rd_chk("rd_unused", 4'd9, 32'd0);

        // Build PEND=0xF, then reset during ACK
        wr(4'd1, 32'hF);
        wr(4'd4, 32'hF);
        pin_i = 32'd0;
        repeat (6) @(negedge clock);
        pin_i = 32'hF;
        repeat (6) @(negedge clock);
        rd_chk("pend_f", 4'd3, 32'hF);
        rd_chk("raw_f", 4'd5, 32'hF);
        chk("irq_f", {31'd0, irq}, 32'd1);
        rt_valid = 1'b1; rt_we = 1'b0; rt_adr = 4'd3;
        @(negedge clock);
        chk("ack_ready", {31'd0, rt_ready}, 32'd1);
        chk("ack_rdata", rt_dat_r, 32'hF);
        rt_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", {31'd0, rt_ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        rd_chk("pend_after_abort", 4'd3, 32'd0);

        // Reset in the same cycle a request is accepted: no ready at all
        rt_valid = 1'b1; rt_we = 1'b1; rt_adr = 4'd4; rt_dat_w = 32'h1;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ready", {31'd0, rt_ready}, 32'd0);
        rt_valid = 1'b0; rt_we = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        rd_chk("mask_after_abort", 4'd4, 32'd0);
        rd_chk("sync_held", 4'd0, 32'hF);
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
